// File: rtl/k12a_alu_seq.sv
// k12a_alu_seq: clocked ALU with 8 single-cycle ops, iterative shifts/rotate and shift-add multiply.
// Latency: done pulses 1+iterations cycles after the accepting edge (shifts: amt, multiply: WIDTH, others: 0).
// Backpressure: start is taken only while busy=0 (IDLE or DONE cycle); start while busy is dropped.
module k12a_alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [2:0]       cond_sel,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             borrow,
  output logic             overflow,
  output logic             condition
);

  // Counter must be able to hold WIDTH (multiply iteration count).
  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [3:0] OP_PASS_A = 4'd0;
  localparam logic [3:0] OP_AND    = 4'd1;
  localparam logic [3:0] OP_OR     = 4'd2;
  localparam logic [3:0] OP_XOR    = 4'd3;
  localparam logic [3:0] OP_ADD    = 4'd4;
  localparam logic [3:0] OP_SUB    = 4'd5;
  localparam logic [3:0] OP_ASR1   = 4'd6;
  localparam logic [3:0] OP_PASS_B = 4'd7;
  localparam logic [3:0] OP_SHL    = 4'd8;
  localparam logic [3:0] OP_SHR    = 4'd9;
  localparam logic [3:0] OP_SAR    = 4'd10;
  localparam logic [3:0] OP_MULH   = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [2:0]           cond_q, cond_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 neg_q, neg_d;
  logic                 borrow_q, borrow_d;
  logic                 ovf_q, ovf_d;
  logic                 cond_out_q, cond_out_d;

  // Adder and flag signals (always from the latched operands)
  logic [WIDTH-1:0]     add_b;
  logic                 add_cin;
  logic [WIDTH:0]       add_full;
  logic [WIDTH-1:0]     add_sum;
  logic                 f_zero, f_neg, f_borrow, f_ovf, f_slt, f_cond;

  // Datapath helpers
  logic [WIDTH-1:0]     single_res;
  logic                 is_shift, is_mul;
  logic [CNT_W-1:0]     iter_cnt;
  logic [WIDTH-1:0]     shift_step;
  logic [WIDTH:0]       mul_addend;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   work_step;

  // Shared adder: a+b for ADD, a-b (a + ~b + 1) for every other op, plus flags and condition select.
  always_comb begin
    add_cin  = (op_q != OP_ADD);
    add_b    = (op_q == OP_ADD) ? b_q : ~b_q;
    add_full = {1'b0, a_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    add_sum  = add_full[WIDTH-1:0];
    f_zero   = (add_sum == '0);
    f_neg    = add_sum[WIDTH-1];
    f_borrow = ~add_full[WIDTH];
    f_ovf    = (a_q[WIDTH-1] ^ add_sum[WIDTH-1]) & (add_b[WIDTH-1] ^ add_sum[WIDTH-1]);
    f_slt    = f_neg ^ f_ovf;
    case (cond_q)
      3'd0:    f_cond = f_zero;
      3'd1:    f_cond = f_neg;
      3'd2:    f_cond = f_borrow;
      3'd3:    f_cond = f_ovf;
      3'd4:    f_cond = f_borrow;
      3'd5:    f_cond = f_borrow | f_zero;
      3'd6:    f_cond = f_slt;
      default: f_cond = f_slt | f_zero;
    endcase
  end

  // Single-cycle result; shift ops land here only with amt=0, reserved ops pass A through.
  always_comb begin
    case (op_q)
      OP_PASS_A: single_res = a_q;
      OP_AND:    single_res = a_q & b_q;
      OP_OR:     single_res = a_q | b_q;
      OP_XOR:    single_res = a_q ^ b_q;
      OP_ADD:    single_res = add_sum;
      OP_SUB:    single_res = add_sum;
      OP_ASR1:   single_res = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      OP_PASS_B: single_res = b_q;
      default:   single_res = a_q;
    endcase
  end

  // Iteration count and one step of the shifter / shift-add multiplier.
  always_comb begin
    is_shift = (op_q[3:2] == 2'b10);
    is_mul   = (op_q[3:1] == 3'b110);
    iter_cnt = '0;
    if (is_shift) begin
      iter_cnt = {1'b0, b_q[SHAMT_W-1:0]};
    end else if (is_mul) begin
      iter_cnt = MUL_ITERS;
    end

    case (op_q)
      OP_SHL:  shift_step = {work_q[WIDTH-2:0], 1'b0};
      OP_SHR:  shift_step = {1'b0, work_q[WIDTH-1:1]};
      OP_SAR:  shift_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shift_step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
    endcase

    // Accumulator layout: high half = partial product, low half = remaining multiplier bits.
    mul_addend = work_q[0] ? {1'b0, a_q} : '0;
    mul_sum    = {1'b0, work_q[2*WIDTH-1:WIDTH]} + mul_addend;

    if (is_mul) begin
      work_step = {mul_sum, work_q[WIDTH-1:1]};
    end else begin
      work_step = {{WIDTH{1'b0}}, shift_step};
    end
  end

  // Next-state logic: sequencing, operand capture, iteration and output update on DONE entry.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cond_d     = cond_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    result_d   = result_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    borrow_d   = borrow_q;
    ovf_d      = ovf_q;
    cond_out_d = cond_out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_EXEC;
          op_d    = op;
          cond_d  = cond_sel;
          a_d     = operand_a;
          b_d     = operand_b;
        end
      end
      S_EXEC: begin
        work_d = is_mul ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{1'b0}}, a_q};
        cnt_d  = iter_cnt;
        if (iter_cnt != '0) begin
          state_d = S_ITER;
        end else begin
          state_d  = S_DONE;
          result_d = single_res;
        end
      end
      S_ITER: begin
        work_d = work_step;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_d == '0) begin
          state_d  = S_DONE;
          result_d = (op_q == OP_MULH) ? work_step[2*WIDTH-1:WIDTH] : work_step[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Result, flags and condition move together on the edge that enters DONE.
    if (state_d == S_DONE) begin
      zero_d     = f_zero;
      neg_d      = f_neg;
      borrow_d   = f_borrow;
      ovf_d      = f_ovf;
      cond_out_d = f_cond;
    end
  end

  // Registered handshake outputs follow the next state.
  always_comb begin
    busy_d = (state_d == S_EXEC) || (state_d == S_ITER);
    done_d = (state_d == S_DONE);
  end

  // Single state register; reset aborts any operation without a done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      cond_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      work_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      borrow_q   <= 1'b0;
      ovf_q      <= 1'b0;
      cond_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cond_q     <= cond_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      borrow_q   <= borrow_d;
      ovf_q      <= ovf_d;
      cond_out_q <= cond_out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign borrow    = borrow_q;
  assign overflow  = ovf_q;
  assign condition = cond_out_q;

endmodule

// File: tb/tb_k12a_alu_seq.sv
// tb_k12a_alu_seq: directed vectors for the sequential K12A ALU (8-bit and 16-bit builds).
// Latency: measured from the accepting edge to the cycle where done is seen.
// Backpressure: exercises ignored starts while busy and back-to-back starts in the DONE cycle.
module tb_k12a_alu_seq;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] op;
  logic [2:0] cond_sel;
  logic [7:0] operand_a, operand_b;
  logic       busy, done;
  logic [7:0] result;
  logic       zero, negative, borrow, overflow, condition;

  logic        start16;
  logic [3:0]  op16;
  logic [2:0]  cond16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [15:0] result16;
  logic        zero16, neg16, borrow16, ovf16, cond_out16;

  int n_chk;
  int n_fail;

  k12a_alu_seq #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .cond_sel(cond_sel),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .result(result), .zero(zero), .negative(negative), .borrow(borrow),
    .overflow(overflow), .condition(condition)
  );

  k12a_alu_seq #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .op(op16), .cond_sel(cond16),
    .operand_a(a16), .operand_b(b16), .busy(busy16), .done(done16),
    .result(result16), .zero(zero16), .negative(neg16), .borrow(borrow16),
    .overflow(ovf16), .condition(cond_out16)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [3:0] op;
    logic [2:0] cs;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flags;  // {zero, negative, borrow, overflow}
    logic       cond;
    int         lat;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request at a negedge; it is accepted on the following rising edge.
  task automatic issue(input logic [3:0] o, input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    start     = 1'b1;
    op        = o;
    cond_sel  = c;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Count cycles from the accepting edge to done; optionally poke start at cycles 2 and 5.
  task automatic wait_done(input bit poke, output int lat, output bit busy_ok);
    bit seen;
    lat     = -1;
    busy_ok = 1'b1;
    seen    = 1'b0;
    @(negedge clock);
    if (!busy || done) busy_ok = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (!seen) begin
        @(negedge clock);
        if (done) begin
          lat  = i;
          seen = 1'b1;
          if (busy) busy_ok = 1'b0;
        end else begin
          if (!busy) busy_ok = 1'b0;
          if (poke) begin
            if (i == 2 || i == 5) begin
              start     = 1'b1;
              op        = 4'd4;
              operand_a = 8'h01;
              operand_b = 8'h01;
            end else begin
              start = 1'b0;
            end
          end
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  bok;
    int  dcount;
    bit  b16ok;

    n_chk  = 0;
    n_fail = 0;

    //          op     cs    a      b      res    zNBO     cond  L
    vecs[0]  = '{4'd5,  3'd4, 8'h05, 8'h07, 8'hFE, 4'b0110, 1'b1, 1};
    vecs[1]  = '{4'd4,  3'd3, 8'h7F, 8'h01, 8'h80, 4'b0111, 1'b1, 1};
    vecs[2]  = '{4'd1,  3'd2, 8'h3C, 8'hF0, 8'h30, 4'b0010, 1'b1, 1};
    vecs[3]  = '{4'd2,  3'd0, 8'h3C, 8'hF0, 8'hFC, 4'b0010, 1'b0, 1};
    vecs[4]  = '{4'd3,  3'd1, 8'h3C, 8'hF0, 8'hCC, 4'b0010, 1'b0, 1};
    vecs[5]  = '{4'd0,  3'd0, 8'h55, 8'h55, 8'h55, 4'b1000, 1'b1, 1};
    vecs[6]  = '{4'd6,  3'd6, 8'h81, 8'h01, 8'hC0, 4'b0100, 1'b1, 1};
    vecs[7]  = '{4'd7,  3'd5, 8'h12, 8'h34, 8'h34, 4'b0110, 1'b1, 1};
    vecs[8]  = '{4'd10, 3'd0, 8'h90, 8'h03, 8'hF2, 4'b0100, 1'b0, 4};
    vecs[9]  = '{4'd8,  3'd0, 8'h90, 8'h08, 8'h90, 4'b0100, 1'b0, 1};
    vecs[10] = '{4'd8,  3'd7, 8'h0B, 8'h02, 8'h2C, 4'b0000, 1'b0, 3};
    vecs[11] = '{4'd9,  3'd4, 8'hF0, 8'h04, 8'h0F, 4'b0100, 1'b0, 5};
    vecs[12] = '{4'd11, 3'd6, 8'h81, 8'h01, 8'h03, 4'b0100, 1'b1, 2};
    vecs[13] = '{4'd12, 3'd2, 8'h0F, 8'h13, 8'h1D, 4'b0110, 1'b1, 9};
    vecs[14] = '{4'd13, 3'd2, 8'h0F, 8'h13, 8'h01, 4'b0110, 1'b1, 9};
    vecs[15] = '{4'd12, 3'd3, 8'hFF, 8'hFF, 8'h01, 4'b1000, 1'b0, 9};
    vecs[16] = '{4'd13, 3'd0, 8'hFF, 8'hFF, 8'hFE, 4'b1000, 1'b1, 9};
    vecs[17] = '{4'd14, 3'd7, 8'h5A, 8'hA5, 8'h5A, 4'b0111, 1'b0, 1};
    vecs[18] = '{4'd15, 3'd3, 8'h80, 8'h01, 8'h80, 4'b0001, 1'b1, 1};
    vecs[19] = '{4'd4,  3'd0, 8'hFF, 8'h01, 8'h00, 4'b1000, 1'b1, 1};
    vecs[20] = '{4'd10, 3'd1, 8'h7F, 8'h07, 8'h00, 4'b0000, 1'b0, 8};

    reset = 1'b1;
    start = 1'b0; op = '0; cond_sel = '0; operand_a = '0; operand_b = '0;
    start16 = 1'b0; op16 = '0; cond16 = '0; a16 = '0; b16 = '0;

    repeat (2) @(negedge clock);
    check("reset ctl8", {31'd0, busy | done}, 32'd0);
    check("reset out8", {19'd0, result, zero, negative, borrow, overflow, condition}, 32'd0);
    check("reset out16", {11'd0, busy16, done16, result16, zero16, neg16, borrow16, ovf16, cond_out16}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Table-driven single operations
    for (int i = 0; i < 21; i++) begin
      issue(vecs[i].op, vecs[i].cs, vecs[i].a, vecs[i].b);
      wait_done(1'b0, lat, bok);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d busy", i), {31'd0, bok}, 32'd1);
      check($sformatf("v%0d result", i), {24'd0, result}, {24'd0, vecs[i].res});
      check($sformatf("v%0d flags", i), {28'd0, zero, negative, borrow, overflow}, {28'd0, vecs[i].flags});
      check($sformatf("v%0d cond", i), {31'd0, condition}, {31'd0, vecs[i].cond});
      @(negedge clock);
      check($sformatf("v%0d done pulse", i), {30'd0, done, busy}, 32'd0);
      check($sformatf("v%0d hold", i), {24'd0, result}, {24'd0, vecs[i].res});
    end

    // Starts while busy are ignored; a start in the DONE cycle is taken with no gap.
    issue(4'd12, 3'd2, 8'h0F, 8'h13);
    wait_done(1'b1, lat, bok);
    check("ignore latency", lat, 9);
    check("ignore busy", {31'd0, bok}, 32'd1);
    check("ignore result", {24'd0, result}, 32'h1D);
    check("ignore flags", {28'd0, zero, negative, borrow, overflow}, 32'b0110);
    issue(4'd10, 3'd0, 8'h90, 8'h03);
    wait_done(1'b0, lat, bok);
    check("b2b latency", lat, 4);
    check("b2b busy", {31'd0, bok}, 32'd1);
    check("b2b result", {24'd0, result}, 32'hF2);

    // Reset in the middle of a multiply: outputs clear at once, no done follows.
    @(negedge clock);
    issue(4'd12, 3'd1, 8'h0F, 8'h13);
    repeat (4) @(negedge clock);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort ctl", {30'd0, busy, done}, 32'd0);
    check("abort out", {19'd0, result, zero, negative, borrow, overflow, condition}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done || busy) dcount++;
    end
    check("abort no done", dcount, 0);

    // 16-bit build: rotate left by 4
    start16 = 1'b1; op16 = 4'd11; cond16 = 3'd3; a16 = 16'h8001; b16 = 16'h0004;
    @(posedge clock);
    #1;
    start16 = 1'b0;
    lat   = -1;
    b16ok = 1'b1;
    @(negedge clock);
    if (!busy16) b16ok = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (lat < 0) begin
        @(negedge clock);
        if (done16) lat = i;
        else if (!busy16) b16ok = 1'b0;
      end
    end
    check("w16 latency", lat, 5);
    check("w16 busy", {31'd0, b16ok}, 32'd1);
    check("w16 result", {16'd0, result16}, 32'h0018);
    check("w16 flags", {28'd0, zero16, neg16, borrow16, ovf16}, 32'b0001);
    check("w16 cond", {31'd0, cond_out16}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/k12a_alu_seq.md
Name: k12a_alu_seq

Overview:
Parametrised, clocked successor to the K12A combinational ALU. It keeps the 8 single-cycle operations and the 8 condition codes. It adds multi-bit iterative shifts/rotate and shift-add multiply, with a start/busy/done handshake and registered result and flags. It sits between the register file and the data-bus driver; the bus tri-state driver stays external.

Parameters:
WIDTH, 8, operand/result width in bits (power of two, >= 4)
SHAMT_W, $clog2(WIDTH), width of the shift amount taken from operand_b[SHAMT_W-1:0]

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  4  operation code, sampled on accept
cond_sel  input  3  condition select, sampled on accept
operand_a  input  WIDTH  first operand, sampled on accept
operand_b  input  WIDTH  second operand or shift amount, sampled on accept
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result, flags and condition are valid
result  output  WIDTH  operation result, held until the next done
zero  output  1  adder output == 0
negative  output  1  adder output MSB
borrow  output  1  ~carry_out of the adder
overflow  output  1  signed overflow of the adder
condition  output  1  selected condition, held with result

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE; busy, done, result, zero, negative, borrow, overflow and condition all 0; iteration counter and accumulators cleared. No done is issued for an aborted operation.
- States:
  - IDLE/DONE -> start -> EXEC. Operands, op and cond_sel are latched on the accepting edge.
  - EXEC -> ITER when iterations > 0, otherwise -> DONE.
  - ITER -> DONE when the counter reaches 0.
  - DONE lasts one cycle (done=1, busy=0), then -> IDLE unless start is also accepted.
- busy=1 in EXEC and ITER. start while busy=1 is ignored, and latched operands are unaffected.
- Latency L: start accepted at edge k; done is high in the cycle after edge k+L, where L = 1 + iterations.
- Back-to-back: start in the DONE cycle is accepted, so the next operation's done arrives L cycles later.
- Single-cycle ops (iterations=0):
  - 0 PASS_A
  - 1 AND
  - 2 OR
  - 3 XOR
  - 4 ADD (a+b)
  - 5 SUB (a-b)
  - 6 ASR1 (a arithmetic right by 1)
  - 7 PASS_B
- Iterative shifts (1 bit per cycle, iterations = amt = operand_b[SHAMT_W-1:0]):
  - 8 SHL
  - 9 SHR logical
  - 10 SAR
  - 11 ROL
  - amt=0 gives L=1 and result = a.
- Multiply (iterations=WIDTH, shift-add using a 2*WIDTH unsigned accumulator):
  - 12 MUL returns the low WIDTH bits of a*b.
  - 13 MULH returns the high WIDTH bits of the unsigned a*b.
- Ops 14 and 15 are reserved and behave exactly as PASS_A.
- Flags are always adder-derived from the latched operands, independent of the result:
  - Adder computes a+b for op 4 and a + ~b + 1 for every other op.
  - overflow = (a[MSB]^s[MSB]) & (b'[MSB]^s[MSB]), where b' is the adder's second input.
- condition by cond_sel:
  - 0 zero
  - 1 negative
  - 2 borrow
  - 3 overflow
  - 4 ult = borrow
  - 5 ule = borrow|zero
  - 6 slt = negative^overflow
  - 7 sle = slt|zero
- result, the flags and condition update together on the edge that enters DONE, and hold until the next DONE or reset.
- All arithmetic is modulo 2^WIDTH; no X outputs in any state.

Test Plan:
1. Reset, then SUB a=0x05 b=0x07 cond_sel=4 -> done 1 cycle after accept; result 0xFE, borrow=1, negative=1, zero=0, overflow=0, condition=1.
2. ADD a=0x7F b=0x01 cond_sel=3 -> result 0x80, overflow=1, negative=1, borrow=1, condition=1. Then AND 0x3C,0xF0 -> result 0x30 with flags from 0x3C-0xF0: borrow=1, zero=0.
3. SAR a=0x90 b=0x03 -> busy 4 cycles, done at L=4, result 0xF2. Then SHL with b=0x08 (amt=0) -> L=1, result 0x90-style passthrough of a.
4. MUL a=0x0F b=0x13 -> done at L=9, result 0x1D. MULH with the same operands -> 0x01. Flags for the MUL: borrow=1, negative=1.
5. Pulse start at cycles 2 and 5 of a running MUL -> ignored, result unchanged. Start in the DONE cycle -> accepted; second done exactly L cycles later with no idle gap.
6. Assert reset at cycle 4 of a MUL -> busy, done and all outputs 0 immediately, no later done. WIDTH=16 build: ROL a=0x8001 b=0x0004 -> L=5, result 0x0018.
